// File: rtl/vdp_sprite_engine.sv
// Sprite overlay stage of the VDP pixel pipeline: double-buffered sprite registers,
// a two-stage hit/colour pipeline, and per-frame sprite collision reporting.
module vdp_sprite_engine #(
  parameter int HPOS_WIDTH       = 10,
  parameter int VPOS_WIDTH       = 10,
  parameter int N_SPRITES        = 4,
  parameter int SPRITE_IDX_WIDTH = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          wr_en,
  input  logic [SPRITE_IDX_WIDTH+1:0]   wr_addr,
  input  logic [31:0]                   wr_data,
  input  logic                          display_on,
  input  logic [HPOS_WIDTH-1:0]         hpos,
  input  logic [VPOS_WIDTH-1:0]         vpos,
  input  logic [2:0]                    bg_rgb,
  output logic [2:0]                    rgb_out,
  output logic                          display_on_out,
  output logic [N_SPRITES-1:0]          collision
);

  logic [HPOS_WIDTH-1:0] pend_x    [N_SPRITES];
  logic [VPOS_WIDTH-1:0] pend_y    [N_SPRITES];
  logic [2:0]            pend_col  [N_SPRITES];
  logic                  pend_en   [N_SPRITES];
  logic [63:0]           pend_rows [N_SPRITES];

  logic [HPOS_WIDTH-1:0] act_x     [N_SPRITES];
  logic [VPOS_WIDTH-1:0] act_y     [N_SPRITES];
  logic [2:0]            act_col   [N_SPRITES];
  logic                  act_en    [N_SPRITES];
  logic [63:0]           act_rows  [N_SPRITES];

  logic [SPRITE_IDX_WIDTH-1:0] wr_idx;
  logic [1:0]                  wr_reg;
  logic                        frame_start;

  assign wr_idx      = wr_addr[SPRITE_IDX_WIDTH+1:2];
  assign wr_reg      = wr_addr[1:0];
  assign frame_start = (hpos == '0) && (vpos == '0);

  // Rows are kept as one 64-bit word: row r is byte r, reg2 the low half, reg3 the high half.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        pend_x[i]    <= '0;
        pend_y[i]    <= '0;
        pend_col[i]  <= '0;
        pend_en[i]   <= 1'b0;
        pend_rows[i] <= '0;
      end
    end else if (wr_en) begin
      case (wr_reg)
        2'd0: begin
          pend_x[wr_idx] <= wr_data[HPOS_WIDTH-1:0];
          pend_y[wr_idx] <= wr_data[16 +: VPOS_WIDTH];
        end
        2'd1: begin
          pend_col[wr_idx] <= wr_data[2:0];
          pend_en[wr_idx]  <= wr_data[31];
        end
        2'd2:    pend_rows[wr_idx][31:0]  <= wr_data;
        default: pend_rows[wr_idx][63:32] <= wr_data;
      endcase
    end
  end

  // The copy takes the pre-write pending value, so a frame-start write lands a frame later.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) begin
        act_x[i]    <= '0;
        act_y[i]    <= '0;
        act_col[i]  <= '0;
        act_en[i]   <= 1'b0;
        act_rows[i] <= '0;
      end
    end else if (frame_start) begin
      act_x    <= pend_x;
      act_y    <= pend_y;
      act_col  <= pend_col;
      act_en   <= pend_en;
      act_rows <= pend_rows;
    end
  end

  logic [HPOS_WIDTH-1:0] dx [N_SPRITES];
  logic [VPOS_WIDTH-1:0] dy [N_SPRITES];

  always_comb begin
    for (int i = 0; i < N_SPRITES; i++) begin
      dx[i] = hpos - act_x[i];
      dy[i] = vpos - act_y[i];
    end
  end

  logic [N_SPRITES-1:0] s1_inside;
  logic [2:0]           s1_dx [N_SPRITES];
  logic [2:0]           s1_dy [N_SPRITES];
  logic [2:0]           s1_bg;
  logic                 s1_don;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_inside <= '0;
      s1_bg     <= '0;
      s1_don    <= 1'b0;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_dx[i] <= '0;
        s1_dy[i] <= '0;
      end
    end else begin
      s1_bg  <= bg_rgb;
      s1_don <= display_on;
      for (int i = 0; i < N_SPRITES; i++) begin
        s1_inside[i] <= act_en[i] && (dx[i][HPOS_WIDTH-1:3] == '0)
                                  && (dy[i][VPOS_WIDTH-1:3] == '0);
        s1_dx[i]     <= dx[i][2:0];
        s1_dy[i]     <= dy[i][2:0];
      end
    end
  end

  logic [N_SPRITES-1:0] opaque;
  logic                 hit;
  logic [2:0]           hit_col;
  logic                 multi_hit;

  // Bit index {dy, ~dx} selects row dy, pixel 7-dx (bit 7 is the leftmost pixel).
  always_comb begin
    opaque  = '0;
    hit     = 1'b0;
    hit_col = '0;
    for (int i = 0; i < N_SPRITES; i++) begin
      opaque[i] = s1_inside[i] && act_rows[i][{s1_dy[i], ~s1_dx[i]}];
    end
    for (int i = N_SPRITES - 1; i >= 0; i--) begin
      if (opaque[i]) begin
        hit     = 1'b1;
        hit_col = act_col[i];
      end
    end
    multi_hit = |(opaque & (opaque - N_SPRITES'(1)));
  end

  logic [N_SPRITES-1:0] coll_acc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rgb_out        <= '0;
      display_on_out <= 1'b0;
      collision      <= '0;
      coll_acc       <= '0;
    end else begin
      rgb_out        <= s1_don ? (hit ? hit_col : s1_bg) : 3'b000;
      display_on_out <= s1_don;
      if (frame_start) begin
        collision <= coll_acc;
        coll_acc  <= '0;
      end else if (s1_don && multi_hit) begin
        coll_acc <= coll_acc | opaque;
      end
    end
  end

endmodule

// File: tb/tb_vdp_sprite_engine.sv
// Scoreboard bench for vdp_sprite_engine on a reduced 128x64 raster.
module tb_vdp_sprite_engine;

  localparam int H_TOT = 128;
  localparam int V_TOT = 64;
  localparam int H_VIS = 112;
  localparam int V_VIS = 60;

  logic        clk;
  logic        reset;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        display_on;
  logic [9:0]  hpos;
  logic [9:0]  vpos;
  logic [2:0]  bg_rgb;
  logic [2:0]  rgb_out;
  logic        display_on_out;
  logic [3:0]  collision;

  vdp_sprite_engine dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .display_on(display_on), .hpos(hpos), .vpos(vpos), .bg_rgb(bg_rgb),
    .rgb_out(rgb_out), .display_on_out(display_on_out), .collision(collision)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic [2:0]  col;
    logic        en;
    logic [63:0] rows;
  } spr_t;

  typedef struct packed {
    logic [2:0] rgb;
    logic       don;
    logic       chk_coll;
    logic [3:0] coll;
    logic [9:0] h;
    logic [9:0] v;
  } exp_t;

  typedef struct packed {
    logic [3:0]  addr;
    logic [31:0] data;
  } wr_t;

  spr_t m_pend [4];
  spr_t m_act  [4];
  logic [3:0] m_acc;
  logic [3:0] m_coll;
  exp_t sb [$];
  wr_t  wq [$];
  int   n_checks;
  int   n_errors;
  logic mon_en;
  logic rel_pending;

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_pend[i] = '0;
      m_act[i]  = '0;
    end
    m_acc  = '0;
    m_coll = '0;
  endtask

  task automatic model_write(input logic [3:0] addr, input logic [31:0] data);
    int i;
    i = int'(addr[3:2]);
    case (addr[1:0])
      2'd0: begin m_pend[i].x = data[9:0]; m_pend[i].y = data[25:16]; end
      2'd1: begin m_pend[i].col = data[2:0]; m_pend[i].en = data[31]; end
      2'd2: m_pend[i].rows[31:0]  = data;
      default: m_pend[i].rows[63:32] = data;
    endcase
  endtask

  function automatic logic model_opaque(input int i, input int h, input int v);
    logic [9:0] ddx, ddy;
    logic [7:0] row;
    ddx = 10'(h) - m_act[i].x;
    ddy = 10'(v) - m_act[i].y;
    if (!m_act[i].en || ddx > 10'd7 || ddy > 10'd7) return 1'b0;
    row = 8'(m_act[i].rows >> (8 * int'(ddy)));
    return row[7 - int'(ddx)];
  endfunction

  task automatic cycle(input int h, input int v, input bit push);
    exp_t e;
    wr_t  w;
    logic [3:0] o;
    @(negedge clk);
    if (rel_pending) begin
      reset       = 1'b0;
      rel_pending = 1'b0;
      mon_en      = 1'b1;
    end
    hpos       = 10'(h);
    vpos       = 10'(v);
    display_on = (h < H_VIS) && (v < V_VIS);
    bg_rgb     = 3'((h >> 2) ^ v);
    if (h == 0 && v == 0) begin
      for (int i = 0; i < 4; i++) m_act[i] = m_pend[i];
      m_coll = m_acc;
      m_acc  = '0;
    end
    if (wq.size() > 0) begin
      w       = wq.pop_front();
      wr_en   = 1'b1;
      wr_addr = w.addr;
      wr_data = w.data;
      model_write(w.addr, w.data);
    end else begin
      wr_en   = 1'b0;
      wr_addr = '0;
      wr_data = '0;
    end
    for (int i = 0; i < 4; i++) o[i] = model_opaque(i, h, v);
    e.rgb = bg_rgb;
    for (int i = 3; i >= 0; i--) if (o[i]) e.rgb = m_act[i].col;
    if (!display_on) e.rgb = 3'b000;
    if (display_on && $countones(o) >= 2) m_acc = m_acc | o;
    e.don      = display_on;
    e.chk_coll = (h == 5 && v == 0);
    e.coll     = m_coll;
    e.h        = 10'(h);
    e.v        = 10'(v);
    if (push) sb.push_back(e);
  endtask

  task automatic chk(input string name, input logic [3:0] got, input logic [3:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic wr(input logic [3:0] addr, input logic [31:0] data);
    wr_t w;
    w.addr = addr;
    w.data = data;
    wq.push_back(w);
  endtask

  task automatic queue_mid_writes(input int f);
    case (f)
      0: begin
        wr(4'h0, 32'h0032_0064); wr(4'h1, 32'h8000_0002);
        wr(4'h2, 32'hFFFF_FFFF); wr(4'h3, 32'hFFFF_FFFF);
      end
      1: begin
        wr(4'h2, 32'h0000_0080); wr(4'h3, 32'h0000_0000);
        wr(4'h4, 32'h000A_03FC); wr(4'h5, 32'h8000_0006);
        wr(4'h6, 32'h5A5A_5A5A); wr(4'h7, 32'hF0F0_0F0F);
      end
      2: begin
        wr(4'h0, 32'h0014_001E); wr(4'h1, 32'h8000_0001);
        wr(4'h2, 32'hFFFF_FFFF); wr(4'h3, 32'hFFFF_FFFF);
        wr(4'h4, 32'h0016_0021); wr(4'h5, 32'h8000_0004);
        wr(4'h6, 32'hFFFF_FFFF); wr(4'h7, 32'hFFFF_FFFF);
      end
      3: wr(4'h4, 32'h0028_003C);
      5: wr(4'h4, 32'h0016_0021);
      default: ;
    endcase
  endtask

  // Monitor: one pixel leaves the pipeline per cycle, two cycles behind its stimulus.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en && sb.size() >= 2) begin
      e = sb.pop_front();
      n_checks++;
      if ({rgb_out, display_on_out} !== {e.rgb, e.don}) begin
        n_errors++;
        $display("FAIL pixel h=%0d v=%0d: rgb/don got %b/%b expected %b/%b",
                 e.h, e.v, rgb_out, display_on_out, e.rgb, e.don);
      end
      if (e.chk_coll) begin
        n_checks++;
        if (collision !== e.coll) begin
          n_errors++;
          $display("FAIL collision at v=%0d h=%0d: got %b expected %b",
                   e.v, e.h, collision, e.coll);
        end
      end
    end
  end

  initial begin
    int hmax, vmax;
    n_checks    = 0;
    n_errors    = 0;
    mon_en      = 1'b0;
    rel_pending = 1'b0;
    reset       = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    display_on = 1'b0; hpos = '0; vpos = '0; bg_rgb = '0;
    model_clear();
    repeat (3) @(negedge clk);
    chk("reset rgb_out", {1'b0, rgb_out}, 4'b0000);
    chk("reset display_on_out", {3'b000, display_on_out}, 4'b0000);
    chk("reset collision", collision, 4'b0000);
    rel_pending = 1'b1;

    for (int f = 0; f <= 8; f++) begin
      vmax = (f == 8) ? 1 : V_TOT;
      for (int v = 0; v < vmax; v++) begin
        hmax = (f == 8) ? 12 : H_TOT;
        for (int h = 0; h < hmax; h++) begin
          if (f == 5 && h == 0 && v == 0) wr(4'h1, 32'h8000_0007);
          if (h == 50 && v == 30) queue_mid_writes(f);
          cycle(h, v, 1'b1);
          if (f == 7 && h == 32 && v == 23) begin
            #2;
            reset  = 1'b1;
            mon_en = 1'b0;
            #1;
            chk("mid-frame reset rgb_out", {1'b0, rgb_out}, 4'b0000);
            chk("mid-frame reset display_on_out", {3'b000, display_on_out}, 4'b0000);
            chk("mid-frame reset collision", collision, 4'b0000);
            sb.delete();
            model_clear();
            cycle(33, 23, 1'b0);
            cycle(34, 23, 1'b0);
            cycle(35, 23, 1'b0);
            rel_pending = 1'b1;
            h = 35;
          end
        end
      end
    end
    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/vdp_sprite_engine.md
Name: vdp_sprite_engine

Overview:
- Pixel-pipeline stage directly downstream of vdp_hv_sync_generator, inside the VDP.
- Consumes hpos/vpos/display_on plus a background colour, overlays N_SPRITES 8x8 monochrome sprites, and produces the final 3-bit VGA colour.
- Sprite registers are written through a simple write port driven by the VDP's registered AHB write decode.
- Register updates are double-buffered and take effect at frame start, so there is no tearing. Per-sprite collision flags are reported once per frame.

Parameters:
- HPOS_WIDTH, 10, width of hpos and sprite X.
- VPOS_WIDTH, 10, width of vpos and sprite Y.
- N_SPRITES, 4, number of sprites; must be a power of two.
- SPRITE_IDX_WIDTH, 2, log2(N_SPRITES).

Ports:
- clk  input  1  system clock (HCLK).
- reset  input  1  asynchronous, active-high reset.
- wr_en  input  1  register write strobe, one write per cycle.
- wr_addr  input  SPRITE_IDX_WIDTH+2  {sprite index, reg[1:0]}.
- wr_data  input  32  write data.
- display_on  input  1  from sync generator.
- hpos  input  HPOS_WIDTH  from sync generator.
- vpos  input  VPOS_WIDTH  from sync generator.
- bg_rgb  input  3  background colour aligned with hpos/vpos.
- rgb_out  output  3  final pixel colour, 2-cycle latency.
- display_on_out  output  1  display_on delayed 2 cycles.
- collision  output  N_SPRITES  per-sprite collision flags for the previous frame.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (reset). On reset, all pending/active registers, pipeline registers, rgb_out, display_on_out, collision and the accumulator go to 0. All sprites are disabled.
- Register map per sprite:
  - reg0: X = wr_data[HPOS_WIDTH-1:0], Y = wr_data[16+VPOS_WIDTH-1:16].
  - reg1: colour = [2:0], enable = [31].
  - reg2: rows 0..3.
  - reg3: rows 4..7.
  - Row r occupies bits [8*(r%4)+7 : 8*(r%4)]; bit 7 is the leftmost pixel (dx=0).
- Writes land in pending registers on the clk edge where wr_en=1.
- frame_start = (hpos==0 && vpos==0), evaluated on the inputs. On that edge the full pending set is copied to the active set.
  - A write in the same cycle updates pending only; active receives the pre-write pending value. The write becomes visible next frame.
- Stage 1 (edge t+1), per sprite, using the active set:
  - dx = hpos - X and dy = vpos - Y, computed modulo 2^width.
  - inside = enable && dx<8 && dy<8.
  - Register inside, dx[2:0] and dy[2:0]. Delay bg_rgb and display_on one stage.
  - Wrap is defined behaviour: X=1020 shows sprite columns 4..7 at hpos 0..3.
- Stage 2 (edge t+2):
  - opaque[i] = inside[i] && row[dy][7-dx].
  - rgb_out = colour of the lowest-index opaque sprite, else delayed bg_rgb.
  - rgb_out is forced to 0 when delayed display_on = 0.
  - display_on_out = display_on delayed 2 cycles.
- Collision:
  - Evaluated at stage 2 only when delayed display_on = 1.
  - If two or more sprites are opaque, OR those sprites' bits into the accumulator.
  - On the frame_start edge: collision <= accumulator, and the accumulator clears to 0. frame_start has priority, so hits in that same cycle are dropped (these are blanking-interval pixels).
- Active and pending sets are never partially updated. Mid-frame writes never alter the displayed frame.
- Reset mid-frame: outputs return to 0 immediately (asynchronous). Sprites stay disabled until written and a frame_start occurs.

Test Plan:
- Reset, no writes, bg_rgb=3'b101, display_on=1 -> rgb_out=3'b101 two cycles after each pixel; display_on_out tracks with 2-cycle lag; collision=0.
- Sprite0 X=100, Y=50, colour=3'b010, enabled, all rows 8'hFF, written mid-frame -> no change this frame. Next frame: rgb_out=3'b010 for hpos 100..107, vpos 50..57, 2 cycles later; background elsewhere.
- Sprite0 row0=8'h80 -> only hpos=100, vpos=50 shows sprite colour. Sprite at X=1020 -> hpos 0..3 shows columns 4..7.
- Sprites 0 and 1 overlap at the same pixel (colours 3'b001 / 3'b100) -> rgb_out=3'b001. At the next frame_start, collision=4'b0011; a frame without overlap then yields collision=0 at the following frame_start.
- Write to reg1 on the exact frame_start cycle -> active keeps the old value for that frame; the new value appears the next frame.
- Assert reset mid-display with sprites active -> rgb_out, display_on_out and collision are 0 at once. After release, sprites stay invisible until rewritten.
